// File: rtl/tx_fcs_ctrl_pkg.sv
// Shared types and constants for the transmit FCS controller.
package tx_fcs_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS
  } fcs_state_e;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          MIN_LEN_DEF   = 60;

  // The shift register runs LSB-first, so the polynomial is used bit-reversed.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/tx_fcs_ctrl_crc.sv
// One-byte step of the reflected CRC-32 (LSB of the data byte enters first).
module crc32_d8
  import tx_fcs_ctrl_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = bit_rev32(CRC32_POLY);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++)
      crc_out = (crc_out >> 1) ^ (((crc_out[0] ^ data[i]) == 1'b1) ? POLY_R : 32'h0);
  end

endmodule

// File: rtl/tx_fcs_ctrl.sv
// Frame transmitter: passes payload through, zero-pads short frames to MIN_LEN
// and appends the CRC-32 FCS, LSB first, through a single registered output slot.
module tx_fcs_ctrl
  import tx_fcs_ctrl_pkg::*;
#(
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Pad_en,
  input  logic [7:0] In_data,
  input  logic       In_valid,
  input  logic       In_last,
  output logic       In_ready,
  output logic [7:0] Out_data,
  output logic       Out_valid,
  output logic       Out_last,
  input  logic       Out_ready,
  output logic       Busy,
  output logic       Frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);

  fcs_state_e       state, state_nx;
  logic [7:0]       data_p1;
  logic             vld_p1, last_p1, done_p1;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [31:0]      crc, crc_cur, crc_nx, fcs_word;
  logic [2:0]       fcs_idx, fcs_idx_nx;
  logic             one_byte, one_nx, pad_lat, pad_nx;
  logic             out_free, out_fire, in_fire;
  logic             ld, ld_crc, ld_last, done_nx;
  logic [7:0]       ld_data;

  function automatic logic go_pad(input logic pad, input logic [CNT_W-1:0] c);
    return pad && (c < MIN_CNT) && (c != CNT_MAX);
  endfunction

  assign out_free = !vld_p1 || Out_ready;
  assign out_fire = vld_p1 && Out_ready;
  // The Frame_done cycle is the mandatory idle gap between frames.
  assign In_ready = (((state == ST_IDLE) && !done_p1) || ((state == ST_DATA) && !one_byte))
                    && out_free;
  assign in_fire  = In_valid && In_ready;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign crc_cur  = (state == ST_IDLE) ? CRC32_SEED : crc;
  assign fcs_word = ~crc;

  crc32_d8 u_crc (
    .data    (ld_data),
    .crc_in  (crc_cur),
    .crc_out (crc_nx)
  );

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    fcs_idx_nx = fcs_idx;
    one_nx     = one_byte;
    pad_nx     = pad_lat;
    ld         = 1'b0;
    ld_crc     = 1'b0;
    ld_last    = 1'b0;
    ld_data    = 8'h00;
    done_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        fcs_idx_nx = 3'd0;
        if (in_fire) begin
          ld       = 1'b1;
          ld_crc   = 1'b1;
          ld_data  = In_data;
          cnt_nx   = CNT_W'(1);
          pad_nx   = Pad_en;
          one_nx   = In_last;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (one_byte) begin
          one_nx   = 1'b0;
          state_nx = go_pad(pad_lat, cnt) ? ST_PAD : ST_FCS;
        end else if (in_fire) begin
          ld      = 1'b1;
          ld_crc  = 1'b1;
          ld_data = In_data;
          cnt_nx  = cnt_inc;
          if (In_last) state_nx = go_pad(pad_lat, cnt_inc) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if (out_free) begin
          ld     = 1'b1;
          ld_crc = 1'b1;
          cnt_nx = cnt_inc;
          if (cnt_inc >= MIN_CNT) state_nx = ST_FCS;
        end
      end
      ST_FCS: begin
        // fcs_idx == 4 means all four bytes are loaded; wait for the last to leave.
        if (fcs_idx != 3'd4) begin
          if (out_free) begin
            ld         = 1'b1;
            ld_data    = fcs_word[8*fcs_idx[1:0] +: 8];
            ld_last    = (fcs_idx == 3'd3);
            fcs_idx_nx = fcs_idx + 3'd1;
          end
        end else if (out_fire) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p1: output slot, running CRC and frame control
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      data_p1  <= 8'h00;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      done_p1  <= 1'b0;
      cnt      <= '0;
      crc      <= CRC32_SEED;
      fcs_idx  <= 3'd0;
      one_byte <= 1'b0;
      pad_lat  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      fcs_idx  <= fcs_idx_nx;
      one_byte <= one_nx;
      pad_lat  <= pad_nx;
      done_p1  <= done_nx;
      if (ld_crc) crc <= crc_nx;
      if (ld) begin
        data_p1 <= ld_data;
        vld_p1  <= 1'b1;
        last_p1 <= ld_last;
      end else if (Out_ready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign Out_data   = data_p1;
  assign Out_valid  = vld_p1;
  assign Out_last   = last_p1;
  assign Frame_done = done_p1;
  assign Busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_fcs_ctrl.sv
// Directed bench for tx_fcs_ctrl: known-answer FCS, padding, throttling,
// reset abort and back-to-back frames.
module tb_tx_fcs_ctrl;

  localparam int MIN_LEN = 60;
  localparam int CNT_W   = 16;

  typedef logic [7:0] bq_t[$];

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Pad_en = 1'b0;
  logic [7:0] In_data = 8'h00;
  logic       In_valid = 1'b0;
  logic       In_last = 1'b0;
  logic       Out_ready = 1'b0;
  logic       In_ready, Out_valid, Out_last, Busy, Frame_done;
  logic [7:0] Out_data;

  always #5 Clk = ~Clk;

  tx_fcs_ctrl #(.MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Pad_en     (Pad_en),
    .In_data    (In_data),
    .In_valid   (In_valid),
    .In_last    (In_last),
    .In_ready   (In_ready),
    .Out_data   (Out_data),
    .Out_valid  (Out_valid),
    .Out_last   (Out_last),
    .Out_ready  (Out_ready),
    .Busy       (Busy),
    .Frame_done (Frame_done)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bq_t  tx_q, rx_q, ref_q, pay;
  bit   tx_last_q[$];
  bit   rx_last_q[$];
  int   done_cnt, rx_pos;
  bit   timed_out, ready_viol, done_gap_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic add_frame(input bq_t p);
    foreach (p[i]) begin
      tx_q.push_back(p[i]);
      tx_last_q.push_back(i == p.size() - 1);
    end
  endtask

  // Streams tx_q until `frames` Frame_done pulses are seen or the budget expires.
  task automatic run(input bit pad, input bit thr, input int frames);
    int idx = 0;
    int cyc = 0;
    bit wait_done = 1'b0;
    bit prev_last_fire = 1'b0;
    rx_q.delete(); rx_last_q.delete();
    done_cnt = 0; timed_out = 0; ready_viol = 0; done_gap_err = 0;
    Pad_en = pad;
    while (done_cnt < frames && cyc < 20000) begin
      In_valid = (idx < tx_q.size()) && (!thr || $urandom_range(0, 3) != 0);
      In_data  = 8'h00;
      In_last  = 1'b0;
      if (In_valid) begin
        In_data = tx_q[idx];
        In_last = tx_last_q[idx];
      end
      Out_ready = !thr || ($urandom_range(0, 2) != 0);
      @(negedge Clk);
      if (Frame_done) begin
        done_cnt++;
        if (!prev_last_fire) done_gap_err = 1'b1;
      end
      if (wait_done && In_ready) ready_viol = 1'b1;
      if (Frame_done) wait_done = 1'b0;
      prev_last_fire = 1'b0;
      if (Out_valid && Out_ready) begin
        rx_q.push_back(Out_data);
        rx_last_q.push_back(Out_last);
        prev_last_fire = Out_last;
      end
      if (In_valid && In_ready) begin
        if (In_last) wait_done = 1'b1;
        idx++;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    In_valid = 1'b0;
    In_last  = 1'b0;
    if (cyc >= 20000) timed_out = 1'b1;
  endtask

  // Checks one received frame starting at rx_pos: length, payload/pad bytes, CRC residue.
  task automatic verify(input string tag, input bq_t p, input bit pad);
    int L = p.size();
    int n = (pad && L < MIN_LEN) ? MIN_LEN : L;
    int fl = 0;
    int bad = 0;
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0] e;
    for (int i = rx_pos; i < rx_q.size(); i++)
      if (rx_last_q[i]) begin
        fl = i - rx_pos + 1;
        break;
      end
    check({tag, "_len"}, 32'(fl), 32'(n + 4));
    for (int i = 0; i < n + 4 && rx_pos + i < rx_q.size(); i++) begin
      c = crc_step(c, rx_q[rx_pos + i]);
      if (i < n) begin
        e = (i < L) ? p[i] : 8'h00;
        if (rx_q[rx_pos + i] !== e) bad++;
      end
    end
    check({tag, "_data_errs"}, 32'(bad), 32'd0);
    check({tag, "_residue"}, c, 32'hDEBB20E3);
    rx_pos = (fl > 0) ? rx_pos + fl : rx_q.size();
  endtask

  task automatic run_checks(input string tag, input int frames);
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'(frames));
    check({tag, "_done_timing"}, 32'(done_gap_err), 32'd0);
    check({tag, "_in_ready_gap"}, 32'(ready_viol), 32'd0);
  endtask

  task automatic check_kat(input string tag);
    check({tag, "_fcs0"}, 32'(rx_q[9]), 32'h26);
    check({tag, "_fcs1"}, 32'(rx_q[10]), 32'h39);
    check({tag, "_fcs2"}, 32'(rx_q[11]), 32'hF4);
    check({tag, "_fcs3"}, 32'(rx_q[12]), 32'hCB);
    check({tag, "_last_on_cb"}, 32'(rx_last_q[12]), 32'd1);
  endtask

  initial begin
    bq_t kat;
    kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(Out_valid), 32'd0);
    check("rst_out_last", 32'(Out_last), 32'd0);
    check("rst_out_data", 32'(Out_data), 32'd0);
    check("rst_frame_done", 32'(Frame_done), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Reset_n = 1'b1;
    Out_ready = 1'b1;
    #1;
    check("idle_in_ready", 32'(In_ready), 32'd1);
    @(posedge Clk); #1;

    // Known-answer frame, no padding
    tx_q.delete(); tx_last_q.delete();
    add_frame(kat);
    run(1'b0, 1'b0, 1);
    run_checks("kat", 1);
    check("kat_rx_count", 32'(rx_q.size()), 32'd13);
    check_kat("kat");
    rx_pos = 0;
    verify("kat", kat, 1'b0);
    check("kat_busy_after", 32'(Busy), 32'd0);

    // One-byte frame padded to MIN_LEN
    pay = '{8'h00};
    tx_q.delete(); tx_last_q.delete();
    add_frame(pay);
    run(1'b1, 1'b0, 1);
    run_checks("pad1", 1);
    check("pad1_rx_count", 32'(rx_q.size()), 32'd64);
    rx_pos = 0;
    verify("pad1", pay, 1'b1);

    // 100-byte frame: unthrottled reference, then throttled on both sides
    pay.delete();
    for (int i = 0; i < 100; i++) pay.push_back(8'((i * 37 + 11) & 8'hFF));
    tx_q.delete(); tx_last_q.delete();
    add_frame(pay);
    run(1'b0, 1'b0, 1);
    run_checks("f100", 1);
    rx_pos = 0;
    verify("f100", pay, 1'b0);
    ref_q = rx_q;
    run(1'b0, 1'b1, 1);
    run_checks("f100thr", 1);
    rx_pos = 0;
    verify("f100thr", pay, 1'b0);
    begin
      int diff = 0;
      for (int i = 0; i < ref_q.size() && i < rx_q.size(); i++)
        if (rx_q[i] !== ref_q[i]) diff++;
      check("f100thr_stream_len", 32'(rx_q.size()), 32'(ref_q.size()));
      check("f100thr_stream_diff", 32'(diff), 32'd0);
    end

    // Reset pulse while padding aborts the frame
    Pad_en = 1'b1;
    Out_ready = 1'b1;
    In_valid = 1'b1;
    In_data = 8'h55;
    In_last = 1'b1;
    @(posedge Clk); #1;
    In_valid = 1'b0;
    In_last = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("pre_abort_busy", 32'(Busy), 32'd1);
    check("pre_abort_valid", 32'(Out_valid), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(Out_valid), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_out_last", 32'(Out_last), 32'd0);
    check("abort_out_data", 32'(Out_data), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    tx_q.delete(); tx_last_q.delete();
    add_frame(kat);
    run(1'b0, 1'b0, 1);
    run_checks("post_abort", 1);
    check("post_abort_rx_count", 32'(rx_q.size()), 32'd13);
    check_kat("post_abort");

    // Two back-to-back 64-byte frames with In_valid held high
    tx_q.delete(); tx_last_q.delete();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i + 1));
    add_frame(pay);
    ref_q = pay;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(8'hC0 ^ i));
    add_frame(pay);
    run(1'b0, 1'b0, 2);
    run_checks("b2b", 2);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd136);
    rx_pos = 0;
    verify("b2b_f1", ref_q, 1'b0);
    verify("b2b_f2", pay, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_fcs_ctrl.md
TX_FCS_CTRL -- requirements
Module: tx_fcs_ctrl

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60: minimum frame length in bytes before FCS, used for padding.
REQ-002 SHALL have parameter CNT_W, default 16: byte-counter width.
REQ-003 Ports (name, direction, width, meaning):
- Clk  in  1  single clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Pad_en  in  1  enable zero-padding up to MIN_LEN; sampled at first byte of each frame.
- In_data  in  8  frame byte.
- In_valid  in  1  In_data valid.
- In_last  in  1  current byte is last payload byte.
- In_ready  out  1  block accepts In_data this cycle.
- Out_data  out  8  output byte.
- Out_valid  out  1  Out_data valid.
- Out_last  out  1  last FCS byte.
- Out_ready  in  1  downstream accepts Out_data.
- Busy  out  1  frame in progress (state != IDLE).
- Frame_done  out  1  one-cycle pulse when the last FCS byte transfers.

Function
REQ-004 Transfer rules: input on In_valid&In_ready; output on Out_valid&Out_ready.
REQ-005 Out_data, Out_valid and Out_last SHALL be registered. Out_valid SHALL stay high with Out_data/Out_last stable until transfer.
REQ-006 In_ready = (state IDLE or DATA) & (!Out_valid | Out_ready). In_ready SHALL be 0 in PAD and FCS.
REQ-007 FSM states and transitions:
- IDLE -> DATA on the first accepted byte.
- DATA -> PAD on accepted In_last when Pad_en(latched)=1 and byte count incl. this byte < MIN_LEN.
- DATA -> FCS on accepted In_last otherwise.
- PAD -> FCS when the padded count reaches MIN_LEN.
- FCS -> IDLE on transfer of the 4th FCS byte.
REQ-008 Each accepted byte SHALL be loaded into the output register in the next cycle (latency 1). Pad bytes are 8'h00, one per output slot.
REQ-009 CRC: CRC-32 (polynomial 0x04C11DB7, reflected, seed 32'hFFFFFFFF, final complement) over all payload and pad bytes. The register is seeded on IDLE->DATA and updated once per byte entering the output register.
REQ-010 FCS bytes SHALL be sent least-significant byte of the final CRC first. The CRC value SHALL be frozen on entry to FCS.
REQ-011 The byte counter SHALL saturate at 2^CNT_W-1. Saturation SHALL NOT disable FCS; padding is never applied on a saturated count.
REQ-012 A 1-byte frame (first byte with In_last) SHALL go IDLE->DATA->PAD/FCS correctly; that byte is counted.
REQ-013 Back-to-back frames: a new first byte SHALL be accepted no earlier than the cycle after Frame_done (IDLE for at least one cycle).
REQ-014 Out_ready held low SHALL stall all states without losing or duplicating bytes, and without advancing the CRC or counters.
REQ-015 In_valid low mid-frame SHALL stall DATA with no bubble bytes inserted in the CRC.
REQ-016 Frame_done SHALL assert in the cycle after the final FCS transfer.

Reset
REQ-017 Reset_n low SHALL asynchronously clear: state=IDLE, Out_valid=0, Out_last=0, Out_data=0, Frame_done=0, Busy=0, counter=0, CRC=32'hFFFFFFFF.
REQ-018 Reset mid-frame SHALL abort the frame with no FCS emitted. The next frame after release starts clean.

Structure
REQ-019 A shared package SHALL hold the FSM state enumeration, the CRC32 polynomial, seed and residue constants, and the MIN_LEN default.
REQ-020 The per-byte CRC next-state logic SHALL be one combinational sub-module, crc32_d8 (8-bit data and 32-bit current CRC in, 32-bit next CRC out), instantiated once.

Verification
REQ-021 Pad_en=0, frame "123456789" (0x31..0x39), Out_ready=1 -> 9 data bytes then 26 39 F4 CB, Out_last on CB, Frame_done one cycle later.
REQ-022 Pad_en=1, 1-byte frame 0x00 -> 1 data byte, 59 bytes of 0x00, 4 FCS bytes, 64 output bytes total. Running CRC over the full 64 bytes equals residue 32'hDEBB20E3 (pre-complement).
REQ-023 Random Out_ready and In_valid throttling on a 100-byte frame -> output byte stream identical to the unthrottled run, no duplicates.
REQ-024 Reset_n pulsed low during PAD -> outputs cleared immediately; a following "123456789" frame yields FCS 26 39 F4 CB.
REQ-025 Two back-to-back 64-byte frames with In_valid held high -> In_ready low during FCS and the IDLE cycle; both FCS values correct; two Frame_done pulses.
